// File: rtl/md_seq_ctrl.sv
// md_seq_ctrl -- EX-stage sequencing controller for the M-extension unit.
//
// Recognises MUL/DIV/REM opcodes in EX and freezes the front of the pipe
// while the fixed-latency multiplier or the iterative divider is working.
// It pulses the divider start and resolves the RISC-V divide-by-zero and
// signed-overflow results locally, without using the divider. The final
// result is latched and presented for exactly one cycle.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   ex_valid, flush   EX holds a valid instruction / kill the in-flight op
//   IDEX_AluOp        EX opcode
//   s1, s2            EX operands (stable while md_stall=1)
//   alu_m_data        M-unit result selected by the datapath
//   div_done          divider finished (1-cycle pulse)
//   div_start         divider start (registered 1-cycle pulse)
//   div_kill          divider abort (registered 1-cycle pulse)
//   md_stall          freeze IF/ID/EX
//   md_busy           controller is not idle
//   md_result         latched final result
//   md_result_valid   md_result is valid this cycle

`ifndef ALU_OP_WIDTH
`define ALU_OP_WIDTH 5
`define ALU_MUL    10
`define ALU_MULH   11
`define ALU_MULHSU 12
`define ALU_MULHU  13
`define ALU_DIV    14
`define ALU_DIVU   15
`define ALU_REM    16
`define ALU_REMU   17
`endif

module md_seq_ctrl #(
    parameter int DATA_WIDTH   = 32,
    parameter int ALU_OP_WIDTH = `ALU_OP_WIDTH,
    parameter int MUL_LAT      = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ex_valid,
    input  logic                    flush,
    input  logic [ALU_OP_WIDTH-1:0] IDEX_AluOp,
    input  logic [DATA_WIDTH-1:0]   s1,
    input  logic [DATA_WIDTH-1:0]   s2,
    input  logic [DATA_WIDTH-1:0]   alu_m_data,
    input  logic                    div_done,
    output logic                    div_start,
    output logic                    div_kill,
    output logic                    md_stall,
    output logic                    md_busy,
    output logic [DATA_WIDTH-1:0]   md_result,
    output logic                    md_result_valid
);

    localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    localparam logic [DATA_WIDTH-1:0] SMIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        MUL_WAIT = 3'd1,
        DIV_WAIT = 3'd2,
        SPECIAL  = 3'd3,
        DONE     = 3'd4
    } state_t;

    state_t                  state, state_d;
    logic [CNT_W-1:0]        cnt;
    logic [ALU_OP_WIDTH-1:0] op_q;
    logic [DATA_WIDTH-1:0]   s1_q;
    logic                    dz_q;      // special case is divide-by-zero (else overflow)

    logic                    is_mul, is_div, is_sdiv, s2_zero, s_ovf, accept;
    logic                    rem_q, latch, start_d, kill_d, stall_c;
    logic [DATA_WIDTH-1:0]   result_d, special_val;

    // Opcode decode of the instruction currently in EX
    always_comb begin
        is_mul  = (IDEX_AluOp == ALU_OP_WIDTH'(`ALU_MUL))    ||
                  (IDEX_AluOp == ALU_OP_WIDTH'(`ALU_MULH))   ||
                  (IDEX_AluOp == ALU_OP_WIDTH'(`ALU_MULHSU)) ||
                  (IDEX_AluOp == ALU_OP_WIDTH'(`ALU_MULHU));
        is_sdiv = (IDEX_AluOp == ALU_OP_WIDTH'(`ALU_DIV))    ||
                  (IDEX_AluOp == ALU_OP_WIDTH'(`ALU_REM));
        is_div  = is_sdiv ||
                  (IDEX_AluOp == ALU_OP_WIDTH'(`ALU_DIVU))   ||
                  (IDEX_AluOp == ALU_OP_WIDTH'(`ALU_REMU));
        s2_zero = (s2 == '0);
        // Only the signed forms can overflow
        s_ovf   = is_sdiv && (s1 == SMIN) && (s2 == '1);
        accept  = (state == IDLE) && ex_valid && !flush && (is_mul || is_div);
    end

    // Special results: div-by-zero gives all-ones / dividend,
    // signed overflow gives MIN / zero.
    assign rem_q = (op_q == ALU_OP_WIDTH'(`ALU_REM)) || (op_q == ALU_OP_WIDTH'(`ALU_REMU));
    assign special_val = dz_q ? (rem_q ? s1_q : '1) : (rem_q ? '0 : SMIN);

    always_comb begin
        state_d  = state;
        stall_c  = 1'b0;
        latch    = 1'b0;
        result_d = md_result;
        start_d  = 1'b0;
        kill_d   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    stall_c = 1'b1;
                    if (is_mul) begin
                        state_d = MUL_WAIT;
                    end else if (s2_zero || s_ovf) begin
                        state_d = SPECIAL;
                    end else begin
                        state_d = DIV_WAIT;
                        start_d = 1'b1;
                    end
                end
            end
            MUL_WAIT: begin
                stall_c = 1'b1;
                if (flush) begin
                    state_d = IDLE;
                end else if (cnt == '0) begin
                    latch    = 1'b1;
                    result_d = alu_m_data;
                    state_d  = DONE;
                end
            end
            DIV_WAIT: begin
                stall_c = 1'b1;
                if (flush) begin
                    state_d = IDLE;
                    kill_d  = 1'b1;
                end else if (div_done && !div_start) begin
                    // A done seen alongside start belongs to a previous divide
                    latch    = 1'b1;
                    result_d = alu_m_data;
                    state_d  = DONE;
                end
            end
            SPECIAL: begin
                stall_c = 1'b1;
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    latch    = 1'b1;
                    result_d = special_val;
                    state_d  = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush) stall_c = 1'b0;
    end

    // Held low while in reset so every output reads 0 during reset
    assign md_stall        = stall_c && rst_n;
    assign md_busy         = (state != IDLE);
    assign md_result_valid = (state == DONE) && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            op_q      <= '0;
            s1_q      <= '0;
            dz_q      <= 1'b0;
            md_result <= '0;
            div_start <= 1'b0;
            div_kill  <= 1'b0;
        end else begin
            state     <= state_d;
            div_start <= start_d;
            div_kill  <= kill_d;
            if (accept) begin
                op_q <= IDEX_AluOp;
                s1_q <= s1;
                dz_q <= s2_zero;
                if (is_mul) cnt <= CNT_W'(MUL_LAT - 1);
            end else if (state == MUL_WAIT && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            if (latch) md_result <= result_d;
        end
    end

endmodule

// File: tb/tb_md_seq_ctrl.sv
`ifndef ALU_OP_WIDTH
`define ALU_OP_WIDTH 5
`define ALU_MUL    10
`define ALU_MULH   11
`define ALU_MULHSU 12
`define ALU_MULHU  13
`define ALU_DIV    14
`define ALU_DIVU   15
`define ALU_REM    16
`define ALU_REMU   17
`endif

module tb_md_seq_ctrl;
    localparam int DW = 32;
    localparam int OW = `ALU_OP_WIDTH;
    localparam int ML = 2;

    localparam logic [OW-1:0] OP_ADD    = OW'(0);
    localparam logic [OW-1:0] OP_MUL    = OW'(`ALU_MUL);
    localparam logic [OW-1:0] OP_MULH   = OW'(`ALU_MULH);
    localparam logic [OW-1:0] OP_MULHSU = OW'(`ALU_MULHSU);
    localparam logic [OW-1:0] OP_MULHU  = OW'(`ALU_MULHU);
    localparam logic [OW-1:0] OP_DIV    = OW'(`ALU_DIV);
    localparam logic [OW-1:0] OP_DIVU   = OW'(`ALU_DIVU);
    localparam logic [OW-1:0] OP_REM    = OW'(`ALU_REM);
    localparam logic [OW-1:0] OP_REMU   = OW'(`ALU_REMU);

    logic          clk, rst_n, ex_valid, flush, div_done;
    logic [OW-1:0] IDEX_AluOp;
    logic [DW-1:0] s1, s2, alu_m_data;
    logic          div_start, div_kill, md_stall, md_busy, md_result_valid;
    logic [DW-1:0] md_result;

    int errors = 0;
    int checks = 0;
    logic [DW-1:0] last_res = '0;

    md_seq_ctrl #(.DATA_WIDTH(DW), .ALU_OP_WIDTH(OW), .MUL_LAT(ML)) dut (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .flush(flush),
        .IDEX_AluOp(IDEX_AluOp), .s1(s1), .s2(s2), .alu_m_data(alu_m_data),
        .div_done(div_done), .div_start(div_start), .div_kill(div_kill),
        .md_stall(md_stall), .md_busy(md_busy), .md_result(md_result),
        .md_result_valid(md_result_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one whole operation from its accept cycle through its DONE cycle.
    // Expected result and latency come straight from the RISC-V rules.
    // The datapath result is only correct in the cycle it is meant to be
    // sampled; every other cycle shows garbage.
    task automatic run_op(input logic [OW-1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic [DW-1:0] mdata, input int k, input bit early_done);
        bit mul, dv, rem, sgn, spec;
        logic [DW-1:0] exp;
        int dc;
        mul = (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_MULHU);
        dv  = (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
        rem = (op == OP_REM) || (op == OP_REMU);
        sgn = (op == OP_DIV) || (op == OP_REM);
        if (!mul && !dv) begin
            ex_valid = 1'b1; IDEX_AluOp = op; s1 = a; s2 = b; flush = 1'b0; div_done = 1'b0;
            #4;
            chk("nonm_stall", DW'(md_stall), 0);
            chk("nonm_busy", DW'(md_busy), 0);
            chk("nonm_valid", DW'(md_result_valid), 0);
            tick();
            ex_valid = 1'b0;
            return;
        end
        spec = 1'b0;
        if (mul) begin
            exp = mdata; dc = ML + 1;
        end else if (b == 0) begin
            spec = 1'b1; exp = rem ? a : 32'hFFFF_FFFF; dc = 2;
        end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            spec = 1'b1; exp = rem ? 32'h0 : 32'h8000_0000; dc = 2;
        end else begin
            exp = mdata; dc = k + 1;
        end
        for (int c = 0; c <= dc; c++) begin
            ex_valid = 1'b1; IDEX_AluOp = op; s1 = a; s2 = b; flush = 1'b0;
            alu_m_data = (!spec && c == dc - 1) ? mdata : ~mdata ^ DW'(c);
            div_done = dv && !spec && (c == k || (early_done && c == 1));
            #4;
            chk($sformatf("stall_c%0d", c), DW'(md_stall), DW'(c < dc));
            chk($sformatf("busy_c%0d", c), DW'(md_busy), DW'(c > 0));
            chk($sformatf("start_c%0d", c), DW'(div_start), DW'(dv && !spec && c == 1));
            chk($sformatf("kill_c%0d", c), DW'(div_kill), 0);
            chk($sformatf("valid_c%0d", c), DW'(md_result_valid), DW'(c == dc));
            chk($sformatf("result_c%0d", c), md_result, (c == dc) ? exp : last_res);
            tick();
        end
        ex_valid = 1'b0; div_done = 1'b0;
        last_res = exp;
    endtask

    initial begin
        logic [OW-1:0] ops [9];
        ops = '{OP_ADD, OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU};
        rst_n = 1'b0; ex_valid = 1'b0; flush = 1'b0; div_done = 1'b0;
        IDEX_AluOp = '0; s1 = '0; s2 = '0; alu_m_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_stall", DW'(md_stall), 0);
        chk("rst_busy", DW'(md_busy), 0);
        chk("rst_start", DW'(div_start), 0);
        chk("rst_kill", DW'(div_kill), 0);
        chk("rst_valid", DW'(md_result_valid), 0);
        chk("rst_result", md_result, 0);
        #2 rst_n = 1'b1;
        tick();

        // Directed cases
        run_op(OP_MULHU, 32'h0, 32'h0, 32'h1234_5678, 0, 1'b0);
        run_op(OP_DIVU, 32'd100, 32'd7, 32'd14, 5, 1'b0);
        run_op(OP_DIV, 32'd55, 32'h0, 32'h0, 0, 1'b0);
        run_op(OP_REMU, 32'hDEAD_BEEF, 32'h0, 32'h0, 0, 1'b0);
        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 0, 1'b0);
        run_op(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 0, 1'b0);
        run_op(OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0001, 3, 1'b1);
        // Back-to-back multiplies, each with its own valid pulse
        run_op(OP_MUL, 32'd3, 32'd4, 32'd12, 0, 1'b0);
        run_op(OP_MULH, 32'd3, 32'd4, 32'hA5A5_0001, 0, 1'b0);

        // Flush in DIV_WAIT cycle 3 together with div_done
        for (int c = 0; c < 3; c++) begin
            ex_valid = 1'b1; IDEX_AluOp = OP_DIV; s1 = 32'd1000; s2 = 32'd3;
            alu_m_data = 32'h0BAD_0BAD; div_done = 1'b0; flush = 1'b0;
            #4;
            chk($sformatf("fl_stall_c%0d", c), DW'(md_stall), 1);
            chk($sformatf("fl_start_c%0d", c), DW'(div_start), DW'(c == 1));
            tick();
        end
        flush = 1'b1; div_done = 1'b1; alu_m_data = 32'h3333_3333;
        #4;
        chk("fl_stall_c3", DW'(md_stall), 0);
        chk("fl_valid_c3", DW'(md_result_valid), 0);
        tick();
        flush = 1'b0; div_done = 1'b0; ex_valid = 1'b0;
        #4;
        chk("fl_kill_c4", DW'(div_kill), 1);
        chk("fl_busy_c4", DW'(md_busy), 0);
        chk("fl_valid_c4", DW'(md_result_valid), 0);
        chk("fl_result_c4", md_result, last_res);
        tick();
        #4;
        chk("fl_kill_c5", DW'(div_kill), 0);
        tick();

        // Reset in the middle of MUL_WAIT
        ex_valid = 1'b1; IDEX_AluOp = OP_MUL; s1 = 32'd9; s2 = 32'd9; alu_m_data = 32'd81;
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_stall", DW'(md_stall), 0);
        chk("mrst_busy", DW'(md_busy), 0);
        chk("mrst_valid", DW'(md_result_valid), 0);
        chk("mrst_result", md_result, 0);
        chk("mrst_start", DW'(div_start), 0);
        chk("mrst_kill", DW'(div_kill), 0);
        ex_valid = 1'b0;
        #1 rst_n = 1'b1;
        last_res = '0;
        tick();
        #4;
        chk("mrst_idle_busy", DW'(md_busy), 0);
        chk("mrst_idle_stall", DW'(md_stall), 0);
        tick();

        // Randomized mix of ops, operand classes and divider latencies
        for (int i = 0; i < 40; i++) begin
            logic [OW-1:0] op;
            logic [DW-1:0] a, b;
            int sel;
            op  = ops[$urandom_range(0, 8)];
            a   = $urandom;
            b   = $urandom;
            sel = $urandom_range(0, 3);
            if (sel == 0) b = '0;
            else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            if ($urandom_range(0, 2) == 0) begin
                // A valid M-op under flush in IDLE must not be accepted
                ex_valid = 1'b1; IDEX_AluOp = OP_DIV; s1 = a; s2 = 32'd5; flush = 1'b1;
                #4;
                chk("idle_flush_stall", DW'(md_stall), 0);
                tick();
                flush = 1'b0; ex_valid = 1'b0;
            end
            run_op(op, a, b, $urandom, $urandom_range(2, 6), 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/md_seq_ctrl.md
# md_seq_ctrl

Sequencing controller for the M-extension datapath in the EX stage. It detects MUL/DIV/REM operations, holds the pipeline while the multi-cycle multiplier or the iterative divider works, and pulses the divider start. It resolves the RISC-V divide-by-zero and signed-overflow cases without using the divider, then latches the final result and presents it for one cycle. It sits between the ID/EX register, the M-unit datapath (operand dispatch, multiplier, divider) and the hazard/stall logic.

## Interface

Parameters:
- DATA_WIDTH, 32, operand/result width
- ALU_OP_WIDTH, `ALU_OP_WIDTH, opcode width
- MUL_LAT, 2, multiplier latency in cycles (≥1)

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst_n  in  1  reset, asynchronous and active-low
- ex_valid  in  1  EX holds a valid instruction
- flush  in  1  kill the in-flight op (branch/trap)
- IDEX_AluOp  in  ALU_OP_WIDTH  EX opcode
- s1, s2  in  DATA_WIDTH  EX operands (held stable while md_stall=1)
- alu_m_data  in  DATA_WIDTH  selected M-unit result from the datapath
- div_done  in  1  divider finished, single-cycle pulse
- div_start  out  1  divider start, single-cycle registered pulse
- div_kill  out  1  divider abort, single-cycle registered pulse
- md_stall  out  1  freeze IF/ID/EX
- md_busy  out  1  state ≠ IDLE
- md_result  out  DATA_WIDTH  latched final result
- md_result_valid  out  1  md_result valid this cycle

## Operation

- **Op classes:**
  - MUL group: `ALU_MUL, `ALU_MULH, `ALU_MULHSU, `ALU_MULHU.
  - DIV group: `ALU_DIV, `ALU_DIVU, `ALU_REM, `ALU_REMU.
  - Any other opcode is ignored and never stalls.
- **State set:** IDLE, MUL_WAIT, DIV_WAIT, SPECIAL, DONE.
- **Accept (IDLE, ex_valid=1, flush=0, M-op):**
  - Latch op_q and s1_q.
  - MUL group: go to MUL_WAIT, cnt=MUL_LAT-1.
  - DIV group with s2==0: go to SPECIAL, with special result:
    - DIV/DIVU: all-ones.
    - REM/REMU: s1.
  - DIV/REM with s1==0x8000_0000 and s2==0xFFFF_FFFF (signed overflow): go to SPECIAL, with special result:
    - DIV: 0x8000_0000.
    - REM: 0.
  - DIVU/REMU are never treated as overflow.
  - All other DIV-group ops: go to DIV_WAIT, with div_start=1 in the first DIV_WAIT cycle.
- **MUL_WAIT:** decrement cnt. When cnt==0, latch md_result←alu_m_data and go to DONE.
- **DIV_WAIT:**
  - div_done is ignored while div_start=1.
  - Otherwise, on div_done, latch md_result←alu_m_data and go to DONE.
  - With no div_done, wait indefinitely (no timeout).
- **SPECIAL:** latch md_result←special value and go to DONE.
- **DONE:** md_result_valid=1 and md_stall=0, so the pipeline advances. Return to IDLE. A new M-op is evaluated only in the following IDLE cycle, so the same instruction is never accepted twice.
- **md_stall (combinational):**
  - 1 in the IDLE accept cycle, MUL_WAIT, DIV_WAIT and SPECIAL.
  - 0 in DONE and whenever flush=1.
- **flush:**
  - In IDLE: blocks accept.
  - In any other state: next state is IDLE, md_result_valid is suppressed and md_result is not updated.
  - From DIV_WAIT: div_kill=1 in the next cycle.
  - flush and div_done in the same cycle: flush wins.
- **md_result:** holds its value until the next latch.

## Timing

- **Reset:** every output is 0, state=IDLE, cnt=0, op_q=0, s1_q=0. Reset mid-operation aborts immediately; no div_kill is generated.
- **Cycle numbering:** cycle 0 is the accept cycle.
- **MUL:** md_stall=1 in cycles 0..MUL_LAT. DONE and md_result_valid occur at cycle MUL_LAT+1. Total occupancy is MUL_LAT+2 cycles.
- **DIV normal:** div_start=1 in cycle 1. If div_done arrives in cycle k (k≥2), md_result_valid occurs at k+1.
- **Special cases:** SPECIAL in cycle 1, md_result_valid in cycle 2. div_start is never asserted.
- **Back-to-back M-ops:** the second op is accepted at the earliest in the cycle after DONE.

## Test plan

- **MULHU:** MULHU, MUL_LAT=2, alu_m_data=0x1234_5678 → md_stall high for cycles 0–2, md_result_valid=1 at cycle 3, md_result=0x1234_5678, div_start never asserted.
- **DIVU normal:** DIVU s1=100 s2=7, div_done at cycle 5, alu_m_data=14 → div_start pulses only in cycle 1, md_result_valid at cycle 6 with md_result=14.
- **Divide by zero:** DIV s2=0 → md_result=0xFFFF_FFFF at cycle 2. REMU s1=0xDEAD_BEEF s2=0 → md_result=0xDEAD_BEEF. No div_start in either case.
- **Signed overflow:**
  - DIV s1=0x8000_0000 s2=0xFFFF_FFFF → md_result=0x8000_0000.
  - REM with the same operands → md_result=0.
  - DIVU with the same operands → normal divider path with div_start.
- **Flush:** flush in cycle 3 of DIV_WAIT → md_stall=0 in cycle 3, div_kill=1 in cycle 4, state IDLE, no md_result_valid. A div_done arriving in cycle 3 is ignored.
- **Reset and back-to-back:**
  - rst_n low mid-MUL_WAIT → all outputs 0 asynchronously, IDLE after release.
  - Two consecutive MULs → second accepted in the cycle after the first DONE, two distinct md_result_valid pulses.
